fsm_result_tx: RTL and testbench
================================

Name: fsm_result_tx

Overview:
- Serial transmitter at the output end of the traffic/sequence FSM.
- Snapshots the FSM result word (E status, R1 and R2 nibbles) whenever it changes, or on request.
- Sends the snapshot as a two-byte UART 8N1 frame on a single pin, so an off-chip reader sees every FSM result without sampling the parallel outputs.
- Sits beside the FSM inside the top wrapper; tx drives a spare bidirectional output pin.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per UART bit (legal range 2..65535; 16-bit baud counter).
- HDR_NIBBLE, 4'hA, upper nibble of header byte, used for frame sync.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- ena  input  1  capture enable; 0 blocks new frames but never truncates one in flight.
- E  input  2  FSM status code.
- R1  input  4  FSM result nibble 1.
- R2  input  4  FSM result nibble 2.
- send  input  1  single-cycle request to retransmit the current value even if unchanged.
- tx  output  1  UART line, idle high.
- busy  output  1  high from capture until the end of the last stop bit.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: one clock, clk edge sampled with rst_n=0.
  - Outputs: tx=1, busy=0, frame_done=0.
  - Internal: state=IDLE, last_sent=10'h000, pending_send=0, baud counter 0, bit index 0, byte index 0.
- States and transitions:
  - IDLE -> START -> DATA (8 bits) -> STOP.
  - STOP of byte 0 -> START of byte 1.
  - STOP of byte 1 -> IDLE.
- Trigger, evaluated in IDLE only: ena=1 and ({E,R1,R2} != last_sent, or send=1, or pending_send=1).
- On a trigger edge:
  - Capture snap={E,R1,R2} and set last_sent=snap.
  - Clear pending_send; busy=1; state=START.
  - tx=0 is visible on the cycle after the trigger edge (1-cycle latency).
- Frame bytes:
  - byte0={HDR_NIBBLE,2'b00,E}.
  - byte1={R1,R2}.
  - Each byte: start bit 0, data LSB first, stop bit 1.
- Bit timing:
  - Every bit holds tx for exactly CLKS_PER_BIT cycles.
  - Whole frame = 20*CLKS_PER_BIT cycles of busy=1.
  - No idle gap between byte0 stop and byte1 start.
- Frame end:
  - On the edge ending the byte1 stop bit: state=IDLE, busy=0, tx stays 1.
  - frame_done=1 for exactly that following cycle.
- Back-to-back frames:
  - A new trigger cannot be taken on the same edge as frame end.
  - It is evaluated on the next edge, so there is always at least one idle cycle between frames.
- Snapshot isolation: input changes while busy never alter the frame in flight.
  - After return to IDLE, the mismatch versus last_sent retriggers with the latest value.
  - Intermediate values are dropped; only the latest is sent.
- send while busy: latched into pending_send and served in IDLE (once, even if pulsed several times).
- send and change in the same cycle: one frame only.
- ena=0 in IDLE: no capture; pending_send and input mismatch persist until ena=1.
- ena=0 while busy: the frame completes normally.
- Reset mid-frame:
  - tx=1 and busy=0 on the next edge; no frame_done.
  - last_sent=0, so a nonzero input retriggers after reset releases.
- Input all zero after reset: no frame unless send.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release with E=0, R1=0, R2=0 -> tx=1, busy=0, frame_done=0 for 100 cycles.
- Basic frame: CLKS_PER_BIT=4, set E=2, R1=3, R2=9 ->
  - tx low starts 1 cycle later.
  - Decoded bytes 0xA2 then 0x39.
  - busy high for 80 cycles, then a single frame_done pulse.
  - No second frame while inputs stay stable.
- Forced resend: with inputs unchanged at 2/3/9, pulse send -> identical 0xA2, 0x39 frame.
  - A send pulse during that frame produces exactly one more frame, after at least one idle cycle.
- Mid-frame change: start a frame for E=1, R1=5, R2=5 (0xA1, 0x55).
  - At cycle 30, change to E=3, R1=0, R2=F, then back to E=1, R1=5, R2=5 at cycle 40.
  - Then change to E=0, R1=7, R2=C at cycle 50.
  - Required: first frame is unaffected, then exactly one frame 0xA0, 0x7C.
- Reset mid-frame: assert rst_n=0 at cycle 25 of a frame -> tx=1, busy=0 next edge, no frame_done.
  - With inputs still nonzero after release, a fresh full frame follows.
- ena gating: ena=0, change inputs to E=1, R1=2, R2=4 -> no activity for 50 cycles.
  - Raise ena -> frame 0xA1, 0x24.
  - Drop ena at frame cycle 10 -> frame still completes.

Source files
------------

// File: rtl/fsm_result_tx_if.sv
// Result/serial bundle between the sequence FSM side and the result transmitter.
//   ena        capture enable
//   E, R1, R2  FSM status code and result nibbles
//   send       single-cycle retransmit request
//   tx         UART line, idle high
//   busy       frame in flight
//   frame_done one-cycle pulse at frame completion
// master: drives the FSM result and control inputs; slave: the transmitter.
interface fsm_result_tx_if;
  logic       ena;
  logic [1:0] E;
  logic [3:0] R1;
  logic [3:0] R2;
  logic       send;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output ena, E, R1, R2, send,
    input  tx, busy, frame_done
  );

  modport slave (
    input  ena, E, R1, R2, send,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/fsm_result_tx.sv
// UART 8N1 transmitter for the FSM result word.
// Snapshots {E, R1, R2} when it differs from the last value sent, or on a send
// request, and emits two bytes: {HDR_NIBBLE, 2'b00, E} then {R1, R2}.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fsm_result_tx_if.slave (ena, E, R1, R2, send in; tx, busy, frame_done out)
module fsm_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [3:0]  HDR_NIBBLE   = 4'hA
) (
  input logic             clk,
  input logic             rst_n,
  fsm_result_tx_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [9:0]  snap_q, snap_d;
  logic [9:0]  last_q, last_d;
  logic        pending_q, pending_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        byte_q, byte_d;
  logic        done_q, done_d;

  logic [9:0]  cur_word;
  logic [7:0]  cur_byte;
  logic        baud_last;
  logic        trigger;
  logic        tx_bit;

  assign cur_word  = {bus.E, bus.R1, bus.R2};
  assign cur_byte  = byte_q ? snap_q[7:0] : {HDR_NIBBLE, 2'b00, snap_q[9:8]};
  assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));
  assign trigger   = (state_q == StIdle) && bus.ena &&
                     ((cur_word != last_q) || bus.send || pending_q);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    last_d    = last_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    // Requests arriving while busy (or while ena is low) wait here until served.
    pending_d = trigger ? 1'b0 : (pending_q | bus.send);

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          snap_d  = cur_word;
          last_d  = cur_word;
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q) begin
            // Leaving via IDLE guarantees at least one idle cycle between frames.
            state_d = StIdle;
            byte_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_d  = 1'b1;
            state_d = StStart;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    unique case (state_q)
      StStart: tx_bit = 1'b0;
      StData:  tx_bit = cur_byte[bit_q];
      default: tx_bit = 1'b1;
    endcase
  end

  assign bus.tx         = tx_bit;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fsm_result_tx.sv
// Self-checking bench for fsm_result_tx with CLKS_PER_BIT = 4.
module tb_fsm_result_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 20 * CPB;

  logic clk;
  logic rst_n;
  fsm_result_tx_if bus ();

  fsm_result_tx #(
    .CLKS_PER_BIT (CPB),
    .HDR_NIBBLE   (4'hA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int scen     = 0;

  typedef struct {
    logic [1:0] e;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       snd;
    logic       frame;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Stimulus injected while a frame is in flight; c = cycle index in the frame.
  task automatic mid_frame(input int c);
    case (scen)
      1: bus.send = (c == 10) || (c == 20);
      2: begin
        if (c == 30) begin bus.E = 2'd3; bus.R1 = 4'h0; bus.R2 = 4'hF; end
        if (c == 40) begin bus.E = 2'd1; bus.R1 = 4'h5; bus.R2 = 4'h5; end
        if (c == 50) begin bus.E = 2'd0; bus.R1 = 4'h7; bus.R2 = 4'hC; end
      end
      3: if (c == 10) bus.ena = 1'b0;
      default: ;
    endcase
  endtask

  // Waits up to max cycles for a start bit; lat = cycles until tx low, or -1.
  task automatic wait_frame(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (i == 1) bus.send = 1'b0;
      if (!bus.tx) begin
        lat = i;
        break;
      end
    end
  endtask

  // Entered at the first start-bit cycle; leaves at the frame_done cycle.
  task automatic rx_frame(input logic [7:0] e0, input logic [7:0] e1, input string tag);
    logic [FRAME-1:0] line;
    logic [7:0] got0, got1;
    logic framing, stable;
    int busy_n, done_n;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < FRAME; c++) begin
      line[c] = bus.tx;
      if (bus.busy) busy_n++;
      if (bus.frame_done) done_n++;
      mid_frame(c);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      got0[j] = line[(1 + j) * CPB + CPB / 2];
      got1[j] = line[(11 + j) * CPB + CPB / 2];
    end
    framing = !line[CPB / 2] && line[9 * CPB + CPB / 2] &&
              !line[10 * CPB + CPB / 2] && line[19 * CPB + CPB / 2];
    stable = 1'b1;
    for (int b = 0; b < 20; b++)
      for (int k = 1; k < CPB; k++)
        if (line[b * CPB + k] !== line[b * CPB]) stable = 1'b0;
    chk({tag, " byte0"}, int'(got0), int'(e0));
    chk({tag, " byte1"}, int'(got1), int'(e1));
    chk({tag, " framing"}, int'(framing), 1);
    chk({tag, " bit_stable"}, int'(stable), 1);
    chk({tag, " busy_cycles"}, busy_n, FRAME);
    chk({tag, " done_inside"}, done_n, 0);
    chk({tag, " end tx/busy/done"}, int'({bus.tx, bus.busy, bus.frame_done}), 3'b101);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int viol;

    vecs[0] = '{2'd2, 4'h3, 4'h9, 1'b0, 1'b1, 8'hA2, 8'h39};
    vecs[1] = '{2'd2, 4'h3, 4'h9, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{2'd2, 4'h3, 4'h9, 1'b1, 1'b1, 8'hA2, 8'h39};
    vecs[3] = '{2'd1, 4'h2, 4'h4, 1'b0, 1'b1, 8'hA1, 8'h24};
    vecs[4] = '{2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 8'hA0, 8'h00};
    vecs[5] = '{2'd3, 4'hF, 4'hF, 1'b0, 1'b1, 8'hA3, 8'hFF};
    vecs[6] = '{2'd3, 4'hF, 4'hF, 1'b1, 1'b1, 8'hA3, 8'hFF};
    vecs[7] = '{2'd2, 4'h3, 4'h9, 1'b0, 1'b1, 8'hA2, 8'h39};

    rst_n = 1'b0;
    bus.ena = 1'b1; bus.E = 2'd0; bus.R1 = 4'h0; bus.R2 = 4'h0; bus.send = 1'b0;
    repeat (3) tick();
    chk("reset tx/busy/done", int'({bus.tx, bus.busy, bus.frame_done}), 3'b100);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({bus.tx, bus.busy, bus.frame_done} !== 3'b100) viol++;
    end
    chk("idle after reset", viol, 0);

    for (int v = 0; v < 8; v++) begin
      bus.E = vecs[v].e; bus.R1 = vecs[v].r1; bus.R2 = vecs[v].r2; bus.send = vecs[v].snd;
      wait_frame(40, lat);
      if (vecs[v].frame) begin
        chk($sformatf("vec%0d latency", v), lat, 1);
        if (lat > 0) rx_frame(vecs[v].b0, vecs[v].b1, $sformatf("vec%0d", v));
      end else begin
        chk($sformatf("vec%0d no_frame", v), lat, -1);
      end
    end

    // Send pulsed twice during a forced resend: exactly one extra frame.
    bus.send = 1'b1;
    wait_frame(10, lat);
    chk("resend latency", lat, 1);
    scen = 1;
    rx_frame(8'hA2, 8'h39, "resend");
    scen = 0;
    wait_frame(10, lat);
    chk("pending latency", lat, 1);
    rx_frame(8'hA2, 8'h39, "pending");
    wait_frame(40, lat);
    chk("pending served once", lat, -1);

    // Mid-frame input churn: first frame intact, then only the latest value.
    bus.E = 2'd1; bus.R1 = 4'h5; bus.R2 = 4'h5;
    wait_frame(10, lat);
    chk("churn latency", lat, 1);
    scen = 2;
    rx_frame(8'hA1, 8'h55, "churn first");
    scen = 0;
    wait_frame(10, lat);
    chk("churn retrigger latency", lat, 1);
    rx_frame(8'hA0, 8'h7C, "churn latest");
    wait_frame(40, lat);
    chk("churn no third", lat, -1);

    // Reset at cycle 25 of a frame.
    bus.E = 2'd2; bus.R1 = 4'h6; bus.R2 = 4'h1;
    wait_frame(10, lat);
    chk("rst frame latency", lat, 1);
    repeat (25) tick();
    rst_n = 1'b0;
    tick();
    chk("midframe reset tx/busy/done", int'({bus.tx, bus.busy, bus.frame_done}), 3'b100);
    rst_n = 1'b1;
    wait_frame(10, lat);
    chk("post reset latency", lat, 1);
    rx_frame(8'hA2, 8'h61, "post reset");

    // ena gating, including a send that waits for ena.
    bus.ena = 1'b0;
    bus.E = 2'd1; bus.R1 = 4'h2; bus.R2 = 4'h4; bus.send = 1'b1;
    wait_frame(50, lat);
    chk("ena low no_frame", lat, -1);
    bus.ena = 1'b1;
    wait_frame(10, lat);
    chk("ena high latency", lat, 1);
    scen = 3;
    rx_frame(8'hA1, 8'h24, "ena drop");
    scen = 0;
    wait_frame(30, lat);
    chk("ena low after frame", lat, -1);
    bus.ena = 1'b1;
    wait_frame(30, lat);
    chk("ena high no stale", lat, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
